// File: rtl/branch_issue_sched.sv
// +--------------------------------------------------------------------------+
// | branch_issue_sched: branch reservation station with oldest-ready issue.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_issue_sched #(
  parameter int DEPTH     = 4,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 5,
  parameter int PAYLOAD_W = 80
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         disp_valid_i,
  output logic                         disp_ready_o,
  input  logic [ROB_W-1:0]             disp_rob_index_i,
  input  logic [PREG_W-1:0]            disp_ps1_i,
  input  logic [PREG_W-1:0]            disp_ps2_i,
  input  logic                         disp_ps1_rdy_i,
  input  logic                         disp_ps2_rdy_i,
  input  logic [PAYLOAD_W-1:0]         disp_payload_i,
  input  logic                         cdb0_valid_i,
  input  logic [PREG_W-1:0]            cdb0_tag_i,
  input  logic                         cdb1_valid_i,
  input  logic [PREG_W-1:0]            cdb1_tag_i,
  input  logic [ROB_W-1:0]             rob_head_i,
  input  logic                         fu_ready_i,
  input  logic                         mispredict_i,
  input  logic [ROB_W-1:0]             mispredict_tag_i,
  output logic                         issue_valid_o,
  output logic [ROB_W-1:0]             issue_rob_index_o,
  output logic [PREG_W-1:0]            issue_ps1_o,
  output logic [PREG_W-1:0]            issue_ps2_o,
  output logic [PAYLOAD_W-1:0]         issue_payload_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AGE_W = 4;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [DEPTH-1:0]     valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [ROB_W-1:0]     rob_q [DEPTH];
  logic [ROB_W-1:0]     rob_d [DEPTH];
  logic [PREG_W-1:0]    ps1_q [DEPTH];
  logic [PREG_W-1:0]    ps1_d [DEPTH];
  logic [PREG_W-1:0]    ps2_q [DEPTH];
  logic [PREG_W-1:0]    ps2_d [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q  [DEPTH];
  logic [PAYLOAD_W-1:0] pl_d  [DEPTH];
  logic [CNT_W-1:0]     count_q, count_d, w_flush_cnt;

  logic                 issue_valid_q;
  logic [ROB_W-1:0]     issue_rob_q;
  logic [PREG_W-1:0]    issue_ps1_q, issue_ps2_q;
  logic [PAYLOAD_W-1:0] issue_pl_q;

  logic [AGE_W-1:0]     w_age [DEPTH];
  logic [AGE_W-1:0]     w_mp_age, w_best_age;
  logic [IDX_W-1:0]     w_free_idx, w_sel_idx;
  logic                 w_sel_found, w_dispatch, w_issue;
  logic [DEPTH-1:0]     w_flush;
  logic                 w_unused_tag_msbs;

  // Age is measured modulo 16; the ROB tag MSB carries no ordering information.
  assign w_unused_tag_msbs = ^{rob_head_i[ROB_W-1:AGE_W], mispredict_tag_i[ROB_W-1:AGE_W]};

  function automatic logic f_hit(input logic [PREG_W-1:0] tag,
                                 input logic v0, input logic [PREG_W-1:0] t0,
                                 input logic v1, input logic [PREG_W-1:0] t1);
    return (tag == '0) || (v0 && (t0 == tag)) || (v1 && (t1 == tag));
  endfunction

  assign disp_ready_o = (count_q < C_DEPTH) & ~mispredict_i;

  always_comb begin
    w_mp_age    = mispredict_tag_i[AGE_W-1:0] - rob_head_i[AGE_W-1:0];
    w_free_idx  = '0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_best_age  = '0;
    w_flush     = '0;
    w_flush_cnt = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) w_free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_age[i] = rob_q[i][AGE_W-1:0] - rob_head_i[AGE_W-1:0];
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i] && (!w_sel_found || (w_age[i] < w_best_age))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_best_age  = w_age[i];
      end
      if (mispredict_i && valid_q[i] && (w_age[i] > w_mp_age)) begin
        w_flush[i]  = 1'b1;
        w_flush_cnt = w_flush_cnt + CNT_W'(1);
      end
    end
    w_dispatch = disp_valid_i & disp_ready_o;
    w_issue    = w_sel_found & fu_ready_i & ~mispredict_i;
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    rob_d   = rob_q;
    ps1_d   = ps1_q;
    ps2_d   = ps2_q;
    pl_d    = pl_q;
    for (int i = 0; i < DEPTH; i++) begin
      rdy1_d[i] = rdy1_q[i] | f_hit(ps1_q[i], cdb0_valid_i, cdb0_tag_i, cdb1_valid_i, cdb1_tag_i);
      rdy2_d[i] = rdy2_q[i] | f_hit(ps2_q[i], cdb0_valid_i, cdb0_tag_i, cdb1_valid_i, cdb1_tag_i);
      if (w_flush[i] || (w_issue && (w_sel_idx == IDX_W'(i)))) valid_d[i] = 1'b0;
      // The free slot is never the issuing one, so dispatch and issue cannot collide.
      if (w_dispatch && (w_free_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b1;
        rob_d[i]   = disp_rob_index_i;
        ps1_d[i]   = disp_ps1_i;
        ps2_d[i]   = disp_ps2_i;
        pl_d[i]    = disp_payload_i;
        rdy1_d[i]  = disp_ps1_rdy_i | f_hit(disp_ps1_i, cdb0_valid_i, cdb0_tag_i, cdb1_valid_i, cdb1_tag_i);
        rdy2_d[i]  = disp_ps2_rdy_i | f_hit(disp_ps2_i, cdb0_valid_i, cdb0_tag_i, cdb1_valid_i, cdb1_tag_i);
      end
    end
    count_d = count_q + CNT_W'(w_dispatch) - CNT_W'(w_issue) - w_flush_cnt;
  end

  always_ff @(posedge clk_i) begin
    rob_q  <= rob_d;
    ps1_q  <= ps1_d;
    ps2_q  <= ps2_d;
    pl_q   <= pl_d;
    rdy1_q <= rdy1_d;
    rdy2_q <= rdy2_d;
    if (reset_i) begin
      valid_q       <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_rob_q   <= '0;
      issue_ps1_q   <= '0;
      issue_ps2_q   <= '0;
      issue_pl_q    <= '0;
    end else begin
      valid_q       <= valid_d;
      count_q       <= count_d;
      issue_valid_q <= w_issue;
      if (w_issue) begin
        issue_rob_q <= rob_q[w_sel_idx];
        issue_ps1_q <= ps1_q[w_sel_idx];
        issue_ps2_q <= ps2_q[w_sel_idx];
        issue_pl_q  <= pl_q[w_sel_idx];
      end
    end
  end

  assign issue_valid_o     = issue_valid_q;
  assign issue_rob_index_o = issue_rob_q;
  assign issue_ps1_o       = issue_ps1_q;
  assign issue_ps2_o       = issue_ps2_q;
  assign issue_payload_o   = issue_pl_q;
  assign count_o           = count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_issue_sched.sv
// +--------------------------------------------------------------------------+
// | tb_branch_issue_sched: directed plus random checks against a queue model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_branch_issue_sched;

  localparam int DEPTH = 4, PREG_W = 7, ROB_W = 5, PAYLOAD_W = 80;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic                 clk = 1'b0;
  logic                 reset, disp_valid, disp_ready, disp_ps1_rdy, disp_ps2_rdy;
  logic [ROB_W-1:0]     disp_rob_index, rob_head, mispredict_tag, issue_rob_index;
  logic [PREG_W-1:0]    disp_ps1, disp_ps2, cdb0_tag, cdb1_tag, issue_ps1, issue_ps2;
  logic [PAYLOAD_W-1:0] disp_payload, issue_payload;
  logic                 cdb0_valid, cdb1_valid, fu_ready, mispredict, issue_valid;
  logic [CNT_W-1:0]     count;

  branch_issue_sched #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk_i(clk), .reset_i(reset),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
    .disp_rob_index_i(disp_rob_index), .disp_ps1_i(disp_ps1), .disp_ps2_i(disp_ps2),
    .disp_ps1_rdy_i(disp_ps1_rdy), .disp_ps2_rdy_i(disp_ps2_rdy), .disp_payload_i(disp_payload),
    .cdb0_valid_i(cdb0_valid), .cdb0_tag_i(cdb0_tag), .cdb1_valid_i(cdb1_valid), .cdb1_tag_i(cdb1_tag),
    .rob_head_i(rob_head), .fu_ready_i(fu_ready),
    .mispredict_i(mispredict), .mispredict_tag_i(mispredict_tag),
    .issue_valid_o(issue_valid), .issue_rob_index_o(issue_rob_index),
    .issue_ps1_o(issue_ps1), .issue_ps2_o(issue_ps2), .issue_payload_o(issue_payload),
    .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROB_W-1:0]     rob;
    logic [PREG_W-1:0]    ps1, ps2;
    bit                   r1, r2;
    logic [PAYLOAD_W-1:0] pl;
  } op_t;

  op_t                  mq[$];
  bit                   exp_iv;
  logic [ROB_W-1:0]     exp_rob;
  logic [PREG_W-1:0]    exp_ps1, exp_ps2;
  logic [PAYLOAD_W-1:0] exp_pl;
  int                   checks = 0;
  int                   errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [PREG_W-1:0] t);
    return (t == '0) || (cdb0_valid && cdb0_tag == t) || (cdb1_valid && cdb1_tag == t);
  endfunction

  function automatic int age(input logic [ROB_W-1:0] r);
    return (int'(r[3:0]) - int'(rob_head[3:0]) + 16) % 16;
  endfunction

  function automatic bit in_use(input logic [ROB_W-1:0] r);
    foreach (mq[i]) if (mq[i].rob[3:0] == r[3:0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    reset = 1'b0; disp_valid = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0; mispredict = 1'b0;
  endtask

  task automatic drive_disp(input logic [ROB_W-1:0] r, input logic [PREG_W-1:0] p1, input bit r1,
                            input logic [PREG_W-1:0] p2, input bit r2);
    disp_valid = 1'b1; disp_rob_index = r;
    disp_ps1 = p1; disp_ps1_rdy = r1; disp_ps2 = p2; disp_ps2_rdy = r2;
    disp_payload = {16'($urandom), $urandom, $urandom};
  endtask

  // One clock: check handshake, advance the model, then check registered outputs.
  task automatic step();
    bit acc;
    int best;
    op_t n;
    #1;
    if (!reset) chk("disp_ready", disp_ready, (mq.size() < DEPTH) && !mispredict);
    if (reset) begin
      mq.delete();
      exp_iv = 0; exp_rob = '0; exp_ps1 = '0; exp_ps2 = '0; exp_pl = '0;
    end else begin
      acc    = disp_valid && (mq.size() < DEPTH) && !mispredict;
      exp_iv = 0;
      if (mispredict) begin
        for (int i = mq.size()-1; i >= 0; i--)
          if (age(mq[i].rob) > age(mispredict_tag)) mq.delete(i);
      end else if (fu_ready) begin
        best = -1;
        foreach (mq[i])
          if (mq[i].r1 && mq[i].r2 && (best < 0 || age(mq[i].rob) < age(mq[best].rob))) best = i;
        if (best >= 0) begin
          exp_iv = 1; exp_rob = mq[best].rob; exp_ps1 = mq[best].ps1;
          exp_ps2 = mq[best].ps2; exp_pl = mq[best].pl;
          mq.delete(best);
        end
      end
      foreach (mq[i]) begin
        if (hit(mq[i].ps1)) mq[i].r1 = 1;
        if (hit(mq[i].ps2)) mq[i].r2 = 1;
      end
      if (acc) begin
        n.rob = disp_rob_index; n.ps1 = disp_ps1; n.ps2 = disp_ps2; n.pl = disp_payload;
        n.r1 = disp_ps1_rdy || hit(disp_ps1);
        n.r2 = disp_ps2_rdy || hit(disp_ps2);
        mq.push_back(n);
      end
    end
    @(posedge clk); #1;
    chk("issue_valid", issue_valid, exp_iv);
    chk("count", count, mq.size());
    chk("issue_rob", issue_rob_index, exp_rob);
    chk("issue_ps1", issue_ps1, exp_ps1);
    chk("issue_ps2", issue_ps2, exp_ps2);
    chk("issue_payload", issue_payload, exp_pl);
  endtask

  initial begin
    int order [3];
    logic [ROB_W-1:0] tg;
    order = '{14, 15, 1};
    idle();
    fu_ready = 1'b1; rob_head = '0; mispredict_tag = '0;
    cdb0_tag = '0; cdb1_tag = '0;
    drive_disp('0, '0, 0, '0, 0); disp_valid = 1'b0;

    // Reset
    reset = 1'b1; step(); step(); idle();
    chk("reset_count", count, 0);
    chk("reset_ready", disp_ready, 1);

    // Ready op issues one edge after dispatch
    drive_disp(5'd3, 7'd5, 1, 7'd0, 1); step();
    idle(); step();
    chk("first_issue_rob", issue_rob_index, 3);
    step();

    // Wakeup through cdb1 three cycles after dispatch
    drive_disp(5'd4, 7'd9, 0, 7'd0, 1); step();
    idle(); step(); step();
    cdb1_valid = 1'b1; cdb1_tag = 7'd9; step();
    idle(); chk("no_early_issue", issue_valid, 0);
    step(); chk("wake_issue", issue_valid, 1);
    step();

    // Wrap-aware age ordering
    rob_head = 5'd14; fu_ready = 1'b0;
    drive_disp(5'd1, 7'd0, 1, 7'd0, 1); step();
    drive_disp(5'd15, 7'd0, 1, 7'd0, 1); step();
    drive_disp(5'd14, 7'd0, 1, 7'd0, 1); step();
    idle(); fu_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk("wrap_order", issue_rob_index, order[k]);
    end
    step();

    // Full scheduler, then one slot frees
    rob_head = 5'd0;
    for (int k = 0; k < 4; k++) begin
      drive_disp(5'(5 + k), 7'(20 + k), 0, 7'd0, 1); step();
    end
    idle();
    chk("full_ready", disp_ready, 0);
    chk("full_count", count, 4);
    drive_disp(5'd9, 7'd0, 1, 7'd0, 1); step();
    idle(); cdb0_valid = 1'b1; cdb0_tag = 7'd20; step();
    idle(); step();
    chk("slot_freed_ready", disp_ready, 1);
    cdb0_valid = 1'b1; cdb0_tag = 7'd21; cdb1_valid = 1'b1; cdb1_tag = 7'd22; step();
    idle(); cdb0_valid = 1'b1; cdb0_tag = 7'd23; step();
    idle(); for (int k = 0; k < 4; k++) step();

    // Mispredict flushes younger entries
    rob_head = 5'd10;
    drive_disp(5'd11, 7'd30, 0, 7'd0, 1); step();
    drive_disp(5'd12, 7'd0, 1, 7'd0, 1); step();
    drive_disp(5'd13, 7'd30, 0, 7'd0, 1); step();
    drive_disp(5'd2, 7'd30, 0, 7'd0, 1); step();
    idle(); mispredict = 1'b1; mispredict_tag = 5'd12; step();
    chk("mp_count", count, 1);
    chk("mp_issue_valid", issue_valid, 0);
    idle(); cdb0_valid = 1'b1; cdb0_tag = 7'd30; step();
    idle(); step();
    chk("mp_survivor", issue_rob_index, 11);
    step();

    // Reset while busy
    rob_head = 5'd0;
    for (int k = 1; k <= 3; k++) begin
      drive_disp(5'(k), 7'd40, 0, 7'd0, 1); step();
    end
    drive_disp(5'd4, 7'd0, 1, 7'd0, 1); step();
    idle(); step();
    chk("busy_issue", issue_valid, 1);
    reset = 1'b1; step();
    idle();
    chk("rst_count", count, 0);
    chk("rst_issue", issue_valid, 0);
    chk("rst_ready", disp_ready, 1);
    cdb0_valid = 1'b1; cdb0_tag = 7'd40; step();
    idle(); for (int k = 0; k < 3; k++) step();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      idle();
      reset    = ($urandom_range(0, 99) == 0);
      fu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) rob_head = 5'($urandom);
      cdb0_valid = 1'($urandom); cdb0_tag = 7'($urandom_range(0, 12));
      cdb1_valid = 1'($urandom); cdb1_tag = 7'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) begin
        mispredict = 1'b1;
        if (mq.size() > 0 && $urandom_range(0, 1) == 1)
          mispredict_tag = mq[$urandom_range(0, mq.size()-1)].rob;
        else
          mispredict_tag = 5'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        tg = 5'($urandom);
        for (int t = 0; t < 64 && in_use(tg); t++) tg = 5'($urandom);
        if (!in_use(tg))
          drive_disp(tg, 7'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0),
                     7'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
